psum_accumulator: RTL and testbench
===================================

# psum_accumulator

- Downstream neighbour of pipeline stage 2 in the convolution datapath; consumes that stage's registered product, `done`, `co_filter` and `stall` outputs.
- Accumulates signed products over one filter window into a saturating partial sum, then queues the result in a 2-entry output buffer for the PSum writer.
- Applies backpressure upstream when the buffer is full, and signals end of computation once every result has drained.

## Interface
- `DATA_WIDTH`, 16: width of incoming signed product.
- `ACC_WIDTH`, 20: width of signed accumulator and `psum_out`; must be at least `DATA_WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input DATA_WIDTH: signed product from pipeline stage 2.
- `stall_in` input 1: high means `in`/`done_in`/`co_filter` carry no new beat this cycle.
- `done_in` input 1: beat is the last of the whole computation.
- `co_filter` input 1: beat is the last product of the current filter window.
- `stall_req` output 1: high means upstream must hold; combinational from buffer state.
- `psum_out` output ACC_WIDTH: head-of-buffer partial sum.
- `psum_sat` output 1: head result saturated at least once during its window.
- `psum_valid` output 1: head entry present.
- `psum_ready` input 1: consumer takes the head when `psum_valid & psum_ready`.
- `done_out` output 1: one-cycle pulse after the final result has been popped.

## Operation
- Accept condition: `acc_en = !stall_in & !stall_req`. Beats arriving with `stall_req` high are ignored; upstream holds them.
- `stall_req = (count == 2)`, where `count` is the buffer occupancy, 0..2.
- Input is sign-extended to ACC_WIDTH.
- First beat of a window: `acc = sext(in)`, `sat = 0`.
- Later beats: `acc = acc + sext(in)`, clamped to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) on overflow. Clamping sets sticky `sat`. Accumulation continues from the clamped value.
- Window close: an accepted beat with `co_filter=1` pushes `{sat, final acc}` (including that beat) into the buffer. The next accepted beat starts a new window.
- Forced close: an accepted beat with `done_in=1` and `co_filter=0` closes the open window exactly as above.
- Buffer: 2-entry FIFO with read pointer, write pointer and `count`.
  - Simultaneous push and pop: `count` unchanged.
  - Pop when empty: no effect, pointers unchanged.
  - Push when full cannot occur, because `acc_en` is 0 when full.
- FSM:
  - IDLE: no open window. An accepted beat moves to ACCUM, or to FLUSH if it carries `done_in`. A single-beat window with `co_filter` stays in IDLE.
  - ACCUM: window open. An accepted beat with `co_filter` and no `done_in` returns to IDLE. An accepted beat with `done_in` goes to FLUSH.
  - FLUSH: all input is ignored. Move to DONE once `count == 0`.
  - DONE: `done_out = 1` for one cycle, then IDLE.
- A `done_in` beat always pushes a result; an empty computation is not supported.

## Timing
- Reset values: `psum_out=0`, `psum_sat=0`, `psum_valid=0`, `stall_req=0`, `done_out=0`. `acc`, `sat`, pointers and `count` are 0. State is IDLE.
- Reset mid-operation discards the partial sum and buffered results, with effect on the next edge.
- Latency: window-closing beat accepted at edge t gives `psum_valid` at t+1 if the buffer was empty.
- Throughput: one beat per cycle while the buffer is not full.
- `stall_req` rises in the cycle after the second push, and falls in the cycle after a pop from full.
- `psum_out`, `psum_sat` and `psum_valid` are stable while `psum_valid & !psum_ready`.
- `done_out` pulses exactly one cycle after the cycle in which the last pop occurred. If the buffer is already empty on entering FLUSH, the pulse comes two cycles after the `done_in` beat.

## Test plan
- Basic window: beats 3, 5, -2 with `co_filter` on -2, `psum_ready=1` → `psum_out=6`, `psum_sat=0`, `psum_valid` one cycle after the -2 beat.
- Saturation, ACC_WIDTH=20: 20 beats of 32767 with `co_filter` on the last → `psum_out=524287`, `psum_sat=1`. The next window of beat 1 with `co_filter` gives `psum_out=1`, `psum_sat=0`.
- Backpressure: `psum_ready=0`, three one-beat windows with values 7, 8, 9 → `stall_req` high after the second. Value 9 is not accepted while `stall_req` is high. Raising `psum_ready` pops 7, 8, 9 in order with no loss or duplication.
- Bubbles: 4, stall, stall, 6 with `co_filter` → `psum_out=10`. Stalled cycles do not change `acc`.
- Forced close and done: 2, 2, then 1 with `done_in=1` and `co_filter=0` → `psum_out=5`. Popping it yields a `done_out` pulse one cycle later. Beats during FLUSH are ignored.
- Reset mid-window: 10, 20, `rst` for one cycle, then 1 with `co_filter` → `psum_out=1`. Outputs are 0 during reset.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// Handshake bundle between pipeline stage 2, the partial-sum accumulator and the PSum writer.
interface psum_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 20
);
    logic signed [DATA_WIDTH-1:0] in;
    logic                         stall_in;
    logic                         done_in;
    logic                         co_filter;
    logic                         stall_req;
    logic signed [ACC_WIDTH-1:0]  psum_out;
    logic                         psum_sat;
    logic                         psum_valid;
    logic                         psum_ready;
    logic                         done_out;

    modport master (
        output in, stall_in, done_in, co_filter, psum_ready,
        input  stall_req, psum_out, psum_sat, psum_valid, done_out
    );

    modport slave (
        input  in, stall_in, done_in, co_filter, psum_ready,
        output stall_req, psum_out, psum_sat, psum_valid, done_out
    );
endinterface

// File: rtl/psum_accumulator.sv
// Saturating per-window accumulation of signed products, queued in a 2-entry buffer
// for the PSum writer, with upstream backpressure and an end-of-computation pulse.
module psum_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 20
) (
    input logic                clk,
    input logic                rst,
    psum_accumulator_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [1:0]                  state;
    logic [1:0]                  state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH:0]          sum;
    logic                        sat;
    logic                        sat_next;

    logic [ACC_WIDTH-1:0]        fifo_acc [2];
    logic                        fifo_sat [2];
    logic                        rptr;
    logic                        wptr;
    logic [1:0]                  count;
    logic [1:0]                  count_next;

    logic                        full;
    logic                        valid;
    logic                        accepting;
    logic                        acc_en;
    logic                        push;
    logic                        pop;

    assign in_ext = ACC_WIDTH'(bus.in);
    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    assign sum    = {acc[ACC_WIDTH-1], acc} + {in_ext[ACC_WIDTH-1], in_ext};

    assign full       = (count == 2'd2);
    assign valid      = (count != 2'd0);
    assign accepting  = (state == IDLE) || (state == ACCUM);
    assign acc_en     = !bus.stall_in && !full && accepting;
    assign push       = acc_en && (bus.co_filter || bus.done_in);
    assign pop        = valid && bus.psum_ready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        acc_next = acc;
        sat_next = sat;
        if (state == IDLE) begin
            acc_next = in_ext;
            sat_next = 1'b0;
        end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_next = 1'b1;
        end else begin
            acc_next = sum[ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (acc_en) begin
                    if (bus.done_in)        state_next = FLUSH;
                    else if (bus.co_filter) state_next = IDLE;
                    else                    state_next = ACCUM;
                end
            end
            // Looking at next occupancy lets done_out follow the last pop by exactly one cycle.
            FLUSH:   if (count_next == 2'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_acc[i] <= '0;
                fifo_sat[i] <= 1'b0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            if (acc_en) begin
                acc <= acc_next;
                sat <= sat_next;
            end
            if (push) begin
                fifo_acc[wptr] <= acc_next;
                fifo_sat[wptr] <= sat_next;
                wptr           <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
        end
    end

    assign bus.stall_req  = full;
    assign bus.psum_valid = valid;
    assign bus.psum_out   = fifo_acc[rptr];
    assign bus.psum_sat   = fifo_sat[rptr];
    assign bus.done_out   = (state == DONE);
endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_psum_accumulator;
    localparam int     DW   = 16;
    localparam int     AW   = 20;
    localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    psum_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint val;
        bit     sat;
    } res_t;

    int     total = 0;
    int     bad   = 0;
    res_t   m_q[$];
    bit     m_open;
    bit     m_sat;
    bit     m_flush;
    bit     m_done;
    longint m_sum;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_open  = 0;
        m_sat   = 0;
        m_flush = 0;
        m_done  = 0;
        m_sum   = 0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.stall_in   = 1'b1;
        bus.in         = '0;
        bus.co_filter  = 1'b0;
        bus.done_in    = 1'b0;
        bus.psum_ready = 1'b0;
        @(negedge clk);
        check("rst_psum_out", bus.psum_out, 0);
        check("rst_psum_sat", bus.psum_sat, 0);
        check("rst_psum_valid", bus.psum_valid, 0);
        check("rst_stall_req", bus.stall_req, 0);
        check("rst_done_out", bus.done_out, 0);
        rst = 1'b0;
        model_clear();
    endtask

    // Drive one cycle at the falling edge, check outputs, advance the model, return at next falling edge.
    task automatic step(input bit s, input longint v, input bit co, input bit dn, input bit rdy);
        bit     acc;
        bit     pop;
        bit     was_flush;
        longint nv;
        bit     ns;
        res_t   r;
        bus.stall_in   = s;
        bus.in         = DW'(v);
        bus.co_filter  = co;
        bus.done_in    = dn;
        bus.psum_ready = rdy;
        check("stall_req", bus.stall_req, m_q.size() == 2);
        check("psum_valid", bus.psum_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("psum_out", bus.psum_out, m_q[0].val);
            check("psum_sat", bus.psum_sat, m_q[0].sat);
        end
        check("done_out", bus.done_out, m_done);
        acc       = !s && (m_q.size() != 2) && !m_flush && !m_done;
        pop       = (m_q.size() != 0) && rdy;
        was_flush = m_flush;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (m_open) begin
                nv = m_sum + v;
                ns = m_sat;
                if (nv > AMAX) begin nv = AMAX; ns = 1; end
                else if (nv < AMIN) begin nv = AMIN; ns = 1; end
            end else begin
                nv = v;
                ns = 0;
            end
            if (co || dn) begin
                r.val = nv;
                r.sat = ns;
                m_q.push_back(r);
                m_open = 0;
            end else begin
                m_open = 1;
                m_sum  = nv;
                m_sat  = ns;
            end
            if (dn) m_flush = 1;
        end
        m_done = 0;
        if (was_flush && m_q.size() == 0) begin
            m_flush = 0;
            m_done  = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        bit     s;
        bit     co;
        bit     dn;
        bit     rdy;
        longint v;

        do_reset();

        step(0, 3, 0, 0, 1);
        step(0, 5, 0, 0, 1);
        step(0, -2, 1, 0, 1);
        check("basic_sum", bus.psum_out, 6);
        check("basic_valid", bus.psum_valid, 1);
        check("basic_sat", bus.psum_sat, 0);
        step(1, 0, 0, 0, 1);

        for (int i = 0; i < 20; i++) step(0, 32767, i == 19, 0, 0);
        check("sat_sum", bus.psum_out, 524287);
        check("sat_flag", bus.psum_sat, 1);
        step(0, 1, 1, 0, 0);
        check("sat_full", bus.stall_req, 1);
        step(1, 0, 0, 0, 1);
        check("after_sat_sum", bus.psum_out, 1);
        check("after_sat_flag", bus.psum_sat, 0);
        step(1, 0, 0, 0, 1);

        step(0, 7, 1, 0, 0);
        step(0, 8, 1, 0, 0);
        check("bp_stall", bus.stall_req, 1);
        step(0, 9, 1, 0, 0);
        check("bp_hold_head", bus.psum_out, 7);
        check("bp_hold_stall", bus.stall_req, 1);
        step(0, 9, 1, 0, 1);
        check("bp_pop1", bus.psum_out, 8);
        check("bp_unstall", bus.stall_req, 0);
        step(0, 9, 1, 0, 1);
        check("bp_pop2", bus.psum_out, 9);
        step(1, 0, 0, 0, 1);
        check("bp_drained", bus.psum_valid, 0);

        step(0, 4, 0, 0, 1);
        step(1, 100, 0, 0, 1);
        step(1, -50, 1, 0, 1);
        step(0, 6, 1, 0, 1);
        check("bubble_sum", bus.psum_out, 10);
        step(1, 0, 0, 0, 1);

        step(0, 2, 0, 0, 1);
        step(0, 2, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        check("forced_sum", bus.psum_out, 5);
        check("forced_valid", bus.psum_valid, 1);
        step(0, 77, 1, 0, 1);
        check("done_pulse", bus.done_out, 1);
        check("flush_ignored", bus.psum_valid, 0);
        step(0, 55, 1, 0, 1);
        check("done_end", bus.done_out, 0);
        check("done_ignored", bus.psum_valid, 0);

        step(0, 10, 0, 0, 1);
        step(0, 20, 0, 0, 1);
        do_reset();
        step(0, 1, 1, 0, 1);
        check("rst_mid_sum", bus.psum_out, 1);
        step(1, 0, 0, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       v = 32767;
                1:       v = -32768;
                default: v = longint'($urandom_range(0, 200)) - 100;
            endcase
            co  = ($urandom_range(0, 9) == 0);
            dn  = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(s, v, co, dn, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
